// File: rtl/vga_pkg.sv
// ============================================================================
// vga_pkg : shared constants, palette and direction type for vga_box_pic
// Revision: 1.0
// ============================================================================
`default_nettype none

package vga_pkg;

  localparam int          H_ACT    = 640;
  localparam int          V_ACT    = 480;
  localparam logic [9:0]  PIC_IDLE = 10'h3FF;
  localparam int          RGB_W    = 12;

  localparam logic [RGB_W-1:0] PALETTE [0:7] = '{
    12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
    12'h0FF, 12'hF0F, 12'hFFF, 12'hF80
  };

  typedef enum logic {FWD = 1'b0, REV = 1'b1} dir_e;

  function automatic logic [RGB_W-1:0] palette_rgb(input logic [2:0] idx);
    return PALETTE[idx];
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_box_motion.sv
// ============================================================================
// vga_box_motion : one-axis bouncing position with clamp-and-flip at 0 / LIM
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_box_motion
  import vga_pkg::*;
#(
  parameter int LIM   = 576,
  parameter int SPEED = 4
) (
  input  logic       vga_clk,
  input  logic       rst_n,
  input  logic       step,
  output logic [9:0] pos,
  output logic       bounce
);

  localparam logic [10:0] LIM_W = 11'(LIM);
  localparam logic [10:0] SPD_W = 11'(SPEED);

  dir_e        dir;
  dir_e        dir_nxt;
  logic [9:0]  pos_nxt;
  logic [10:0] fwd_sum;

  assign fwd_sum = {1'b0, pos} + SPD_W;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= '0;
      dir <= FWD;
    end else begin
      pos <= pos_nxt;
      dir <= dir_nxt;
    end
  end

  // Landing exactly on an end stop is not a bounce; the flip waits for the next step.
  always_comb begin
    pos_nxt = pos;
    dir_nxt = dir;
    bounce  = 1'b0;
    if (step) begin
      case (dir)
        FWD: begin
          if (fwd_sum > LIM_W) begin
            pos_nxt = LIM_W[9:0];
            dir_nxt = REV;
            bounce  = 1'b1;
          end else begin
            pos_nxt = fwd_sum[9:0];
          end
        end
        REV: begin
          if ({1'b0, pos} < SPD_W) begin
            pos_nxt = '0;
            dir_nxt = FWD;
            bounce  = 1'b1;
          end else begin
            pos_nxt = pos - SPD_W[9:0];
          end
        end
        default: begin
          pos_nxt = pos;
          dir_nxt = FWD;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_box_pic.sv
// ============================================================================
// vga_box_pic : bouncing coloured box picture source, 1-cycle registered RGB
// Optional build macro VGA_BOX_BORDER_EN adds a 2-pixel white screen border.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_box_pic
  import vga_pkg::*;
#(
  parameter int               BOX_SIZE = 64,
  parameter int               SPEED    = 4,
  parameter logic [RGB_W-1:0] BG_COLOR = 12'h000
) (
  input  logic             vga_clk,
  input  logic             rst_n,
  input  logic             move_en,
  input  logic [9:0]       pic_x,
  input  logic [9:0]       pic_y,
  output logic [RGB_W-1:0] pic_data
);

  localparam logic [10:0] BOX_W = 11'(BOX_SIZE);

  logic             frame_tick;
  logic             step;
  logic [9:0]       box_x;
  logic [9:0]       box_y;
  logic             bounce_x;
  logic             bounce_y;
  logic [2:0]       col_idx;
  logic             active;
  logic             in_box;
  logic             border;
  logic [RGB_W-1:0] pix_nxt;

  assign frame_tick = (pic_x == 10'(H_ACT - 1)) && (pic_y == 10'(V_ACT - 1));
  assign step       = frame_tick && move_en;

  vga_box_motion #(.LIM(H_ACT - BOX_SIZE), .SPEED(SPEED)) u_motion_x (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .step    (step),
    .pos     (box_x),
    .bounce  (bounce_x)
  );

  vga_box_motion #(.LIM(V_ACT - BOX_SIZE), .SPEED(SPEED)) u_motion_y (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .step    (step),
    .pos     (box_y),
    .bounce  (bounce_y)
  );

  // A corner hit raises both bounces in the same cycle but advances the colour once.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      col_idx <= '0;
    end else if (step && (bounce_x || bounce_y)) begin
      col_idx <= col_idx + 3'd1;
    end
  end

  assign active = (pic_x != PIC_IDLE) && (pic_y != PIC_IDLE) &&
                  (pic_x < 10'(H_ACT)) && (pic_y < 10'(V_ACT));

  assign in_box = ({1'b0, pic_x} >= {1'b0, box_x}) &&
                  ({1'b0, pic_x} <  ({1'b0, box_x} + BOX_W)) &&
                  ({1'b0, pic_y} >= {1'b0, box_y}) &&
                  ({1'b0, pic_y} <  ({1'b0, box_y} + BOX_W));

`ifdef VGA_BOX_BORDER_EN
  assign border = (pic_x < 10'd2) || (pic_x >= 10'(H_ACT - 2)) ||
                  (pic_y < 10'd2) || (pic_y >= 10'(V_ACT - 2));
`else
  assign border = 1'b0;
`endif

  always_comb begin
    pix_nxt = BG_COLOR;
    if (!active) begin
      pix_nxt = '0;
    end else if (border) begin
      pix_nxt = 12'hFFF;
    end else if (in_box) begin
      pix_nxt = palette_rgb(col_idx);
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      pic_data <= '0;
    end else begin
      pic_data <= pix_nxt;
    end
  end

endmodule

`default_nettype wire
